// File: rtl/apb3_mem_slave_if.sv
// rtl/apb3_mem_slave_if.sv - APB3 bus bundle between a requester and apb3_mem_slave
//
// Purpose: groups the APB3 select/enable/address/data/response signals.
// Ports (modport view):
//    master : drives PSELx, PENABLE, PWRITE, PADDR, PWDATA; receives PRDATA, PREADY, PSLVERR
//    slave  : receives PSELx, PENABLE, PWRITE, PADDR, PWDATA; drives PRDATA, PREADY, PSLVERR
interface apb3_mem_slave_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              PSELx;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb3_mem_slave.sv
// rtl/apb3_mem_slave.sv - parametrised APB3 completer fronting a word-addressed memory
//
// Purpose: APB3 completer with programmable wait states, out-of-range error
// response and clean abort when the requester drops PSELx mid-transfer.
// Optional macro RO_REGION_EN: words RO_BASE..DEPTH-1 become write-protected
// (writes there complete with PSLVERR=1 and leave memory unchanged).
// Ports:
//    PCLK     in   clock, rising edge
//    PRESETn  in   asynchronous reset, active-high despite the name
//    bus      slave modport of apb3_mem_slave_if (PSELx, PENABLE, PWRITE,
//             PADDR, PWDATA in; PRDATA, PREADY, PSLVERR out, all registered)
module apb3_mem_slave #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0,
   parameter int RO_BASE     = 768
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   apb3_mem_slave_if.slave    bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef RO_REGION_EN
   localparam bit RO_EN = 1'b1;
`else
   localparam bit RO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [IDX_W-1:0]  addr_q, addr_n;
   logic              write_q, write_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              err_q, err_n;
   logic [DATA_W-1:0] prdata_q, prdata_n;
   logic              pready_q, pready_n;
   logic              pslverr_q, pslverr_n;
   logic              mem_we;

   logic [DATA_W-1:0] mem [DEPTH];

   // Full-width unsigned compares; ADDR_W+1 bits so DEPTH == 2**ADDR_W still fits.
   logic              setup_oor, setup_ro, setup_err;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_word;

   assign setup_oor = ({1'b0, bus.PADDR} >= (ADDR_W+1)'(DEPTH));
   assign setup_ro  = RO_EN && bus.PWRITE && ({1'b0, bus.PADDR} >= (ADDR_W+1)'(RO_BASE));
   assign setup_err = setup_oor || setup_ro;

   // With zero wait states READY is entered on the setup edge itself, so the
   // read must come straight from PADDR rather than the not-yet-latched copy.
   assign rd_idx  = (state == IDLE) ? bus.PADDR[IDX_W-1:0] : addr_q;
   assign rd_word = mem[rd_idx];

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      addr_n    = addr_q;
      write_n   = write_q;
      wdata_n   = wdata_q;
      err_n     = err_q;
      prdata_n  = '0;
      pready_n  = 1'b0;
      pslverr_n = 1'b0;
      mem_we    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.PSELx && !bus.PENABLE) begin
               addr_n  = bus.PADDR[IDX_W-1:0];
               write_n = bus.PWRITE;
               wdata_n = bus.PWDATA;
               err_n   = setup_err;
               if (WAIT_CYCLES == 0) begin
                  state_n   = READY;
                  cnt_n     = '0;
                  pready_n  = 1'b1;
                  pslverr_n = setup_err;
                  prdata_n  = (!bus.PWRITE && !setup_err) ? rd_word : '0;
               end else begin
                  state_n = WAIT;
                  cnt_n   = 4'(WAIT_CYCLES);
               end
            end
         end
         WAIT: begin
            if (!bus.PSELx) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (bus.PENABLE) begin
               if (cnt == 4'd1) begin
                  state_n   = READY;
                  cnt_n     = '0;
                  pready_n  = 1'b1;
                  pslverr_n = err_q;
                  prdata_n  = (!write_q && !err_q) ? rd_word : '0;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
         end
         READY: begin
            // Closing edge: commit only if the requester is still selecting us.
            state_n = IDLE;
            cnt_n   = '0;
            mem_we  = bus.PSELx && write_q && !err_q;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         addr_q    <= addr_n;
         write_q   <= write_n;
         wdata_q   <= wdata_n;
         err_q     <= err_n;
         prdata_q  <= prdata_n;
         pready_q  <= pready_n;
         pslverr_q <= pslverr_n;
      end
   end

   // Memory is deliberately not reset; reset forces IDLE so no write can fire.
   always_ff @(posedge PCLK) begin
      if (mem_we) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign bus.PRDATA  = prdata_q;
   assign bus.PREADY  = pready_q;
   assign bus.PSLVERR = pslverr_q;

endmodule
